sub_arbiter: RTL
================

Name: sub_arbiter

Overview:
- Shares a single 4-bit sign-magnitude subtract unit between NREQ requesters.
- Round-robin arbitration; one operation accepted per cycle.
- Result, sign and requester ID are held in a one-entry registered output stage with valid/ready backpressure.
- Sits between ALU front-end ports and the subtract datapath; it is the only block that drives the shared subtractor.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DATA_W, 4, operand and result width.
- ID_W, 2, requester ID width; must equal clog2(NREQ).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  per-requester operation request.
- req_a  input  NREQ*DATA_W  minuends, requester i at bits [i*DATA_W +: DATA_W].
- req_b  input  NREQ*DATA_W  subtrahends, same packing.
- req_ready  output  NREQ  one-hot grant/accept, at most one bit high.
- rsp_valid  output  1  result register holds a valid result.
- rsp_ready  input  1  consumer accepts the result.
- rsp_mag  output  DATA_W  |a-b|.
- rsp_neg  output  1  1 when a<b.
- rsp_id  output  ID_W  index of the requester that produced the result.

Behaviour:
- Reset is asynchronous, active-low, one clock. On reset:
  - rsp_valid=0, rsp_mag=0, rsp_neg=0, rsp_id=0.
  - Round-robin pointer set to 0; FSM set to EMPTY.
- FSM states:
  - EMPTY: output register free.
  - FULL: output register holds an unconsumed result.
- Accept condition: can_accept = (state==EMPTY) | (rsp_valid & rsp_ready).
- req_ready is combinational:
  - When can_accept, it asserts the first valid requester searching upward (with wrap) from ptr.
  - Otherwise all zero.
- A handshake occurs on req_valid[i] & req_ready[i] at a rising edge. On that edge:
  - The output register loads the winner's result.
  - rsp_valid=1 and state moves to FULL.
  - ptr = (winner+1) mod NREQ.
- Latency: exactly 1 cycle from handshake to rsp_valid.
- Throughput: 1 op per cycle when rsp_ready is held high.
- In FULL with rsp_ready=1 and no request, the next state is EMPTY with rsp_valid=0. The data outputs hold their last values.
- Consume and new accept on the same edge: the new result replaces the old one, state stays FULL, and there is no bubble.
- In FULL with rsp_ready=0, all outputs are held stable and req_ready is all zero.
- ptr advances only on a handshake.
- Arithmetic: diff = a - b, computed in DATA_W+1 bits.
  - rsp_neg = borrow out (a<b).
  - rsp_mag = neg ? (b-a) : (a-b), always DATA_W bits, no overflow.
  - a==b gives mag=0, neg=0.
- Requesters must hold req_a/req_b stable while req_valid is high and not yet granted.
- Fairness: a continuously requesting requester is granted within NREQ handshakes.
- Reset asserted mid-operation discards any held result. No partial state survives.

Optional Feature:
- Macro: SUB_ARB_STATS_EN.
- When defined:
  - Adds output grant_cnt, width NREQ*8: a per-requester 8-bit saturating count of handshakes.
  - Counters reset to 0 asynchronously.
  - Adds input stats_clr (1 bit), a synchronous clear of all counters. A clear and a grant on the same edge gives 0 for that requester.
- When undefined: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Package sub_arb_pkg holds:
  - DATA_W default.
  - typedef sub_state_t {EMPTY, FULL}.
  - typedef sub_rsp_t {mag, neg, id}.
  - Function rr_pick(valid, ptr) returning the one-hot grant.
- One sub-module, sub_magnitude: a purely combinational DATA_W-bit subtract giving magnitude and sign. It is instantiated once and fed by the granted requester's mux.
- Arbitration, the FSM and the output register stay in sub_arbiter.

Test Plan:
- Reset with all inputs active → rsp_valid=0, req_ready=0 during reset. First grant after release goes to req0.
- Single request, req1: a=9, b=3, rsp_ready=1 → next cycle rsp_valid=1, mag=6, neg=0, id=1. Following cycle rsp_valid=0.
- req2: a=3, b=12 → mag=9, neg=1, id=2. Equal case a=7, b=7 → mag=0, neg=0.
- All four requesting continuously with rsp_ready=1 → grant order 0,1,2,3,0,…, one result per cycle, no bubbles.
- rsp_ready held 0 for 3 cycles after a result → rsp_* stable, req_ready=0. Raising rsp_ready → consume and new accept on the same edge, rsp_valid stays 1.
- Assert rst_n=0 while FULL → immediate rsp_valid=0 and ptr=0. With SUB_ARB_STATS_EN, verify counters saturate at 255 after 300 grants to req0, and stats_clr zeroes them.

Source files
------------

// File: rtl/sub_arb_pkg.sv
// rtl/sub_arb_pkg.sv - shared types, defaults and round-robin pick function for sub_arbiter
package sub_arb_pkg;

  localparam int DATA_W_DEF = 4;
  localparam int MAX_REQ    = 8;
  localparam int PTR_W      = 3;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } sub_state_t;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] mag;
    logic                  neg;
    logic [PTR_W-1:0]      id;
  } sub_rsp_t;

  // One-hot grant: first set bit of valid at or above ptr, wrapping within n requesters.
  function automatic logic [MAX_REQ-1:0] rr_pick(
    input logic [MAX_REQ-1:0] valid,
    input logic [PTR_W-1:0]   ptr,
    input int                 n
  );
    logic [MAX_REQ-1:0] grant;
    logic               found;
    int                 idx;
    logic [PTR_W-1:0]   sel;
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = (int'(ptr) + k) % n;
      sel = idx[PTR_W-1:0];
      if ((k < n) && !found && valid[sel]) begin
        grant[sel] = 1'b1;
        found      = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/sub_magnitude.sv
// rtl/sub_magnitude.sv - combinational sign-magnitude subtract |a-b| with borrow sign
module sub_magnitude
  import sub_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] mag,
  output logic              neg
);

  logic [DATA_W:0] diff;

  // Extra bit carries the borrow; on borrow the magnitude is recomputed as b-a.
  always_comb begin
    diff = {1'b0, a} - {1'b0, b};
    neg  = diff[DATA_W];
    mag  = neg ? (b - a) : diff[DATA_W-1:0];
  end

endmodule

// File: rtl/sub_arbiter.sv
// rtl/sub_arbiter.sv - round-robin arbiter sharing one subtractor, registered output (optional SUB_ARB_STATS_EN grant counters)
module sub_arbiter
  import sub_arb_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ID_W   = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*DATA_W-1:0] req_a,
  input  logic [NREQ*DATA_W-1:0] req_b,
  output logic [NREQ-1:0]        req_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_W-1:0]      rsp_mag,
  output logic                   rsp_neg,
  output logic [ID_W-1:0]        rsp_id
`ifdef SUB_ARB_STATS_EN
  ,
  input  logic                   stats_clr,
  output logic [NREQ*8-1:0]      grant_cnt
`endif
);

  sub_state_t         state;
  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    win_idx;
  logic [ID_W-1:0]    ptr_next;
  logic [MAX_REQ-1:0] valid_ext;
  logic [MAX_REQ-1:0] pick;
  logic               unused_pick;
  logic               can_accept;
  logic               handshake;
  logic [DATA_W-1:0]  sel_a;
  logic [DATA_W-1:0]  sel_b;
  logic [DATA_W-1:0]  sub_mag;
  logic               sub_neg;

  // Widen the request vector to the pick function's fixed width.
  always_comb begin
    valid_ext            = '0;
    valid_ext[NREQ-1:0]  = req_valid;
  end

  assign pick        = rr_pick(valid_ext, PTR_W'(ptr), NREQ);
  assign unused_pick = |pick;

  // A slot is free when empty or when the held result leaves on this edge.
  assign can_accept = (state == EMPTY) | (rsp_valid & rsp_ready);
  assign req_ready  = (rst_n & can_accept) ? pick[NREQ-1:0] : '0;
  assign handshake  = |(req_valid & req_ready);

  // Route the granted requester's operands to the shared subtractor.
  always_comb begin
    win_idx = '0;
    sel_a   = '0;
    sel_b   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        win_idx = ID_W'(i);
        sel_a   = req_a[i*DATA_W +: DATA_W];
        sel_b   = req_b[i*DATA_W +: DATA_W];
      end
    end
    ptr_next = (win_idx == ID_W'(NREQ - 1)) ? '0 : win_idx + 1'b1;
  end

  sub_magnitude #(
    .DATA_W (DATA_W)
  ) u_sub (
    .a   (sel_a),
    .b   (sel_b),
    .mag (sub_mag),
    .neg (sub_neg)
  );

  // Output stage FSM: a new accept always loads, otherwise a consume empties the register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      ptr       <= '0;
      rsp_valid <= 1'b0;
      rsp_mag   <= '0;
      rsp_neg   <= 1'b0;
      rsp_id    <= '0;
    end else if (handshake) begin
      state     <= FULL;
      ptr       <= ptr_next;
      rsp_valid <= 1'b1;
      rsp_mag   <= sub_mag;
      rsp_neg   <= sub_neg;
      rsp_id    <= win_idx;
    end else begin
      case (state)
        EMPTY: begin
          rsp_valid <= 1'b0;
        end
        FULL: begin
          if (rsp_ready) begin
            state     <= EMPTY;
            rsp_valid <= 1'b0;
          end
        end
        default: begin
          state     <= EMPTY;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef SUB_ARB_STATS_EN
  // Per-requester saturating handshake counters; clear wins over a same-edge grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (stats_clr) begin
          grant_cnt[i*8 +: 8] <= 8'd0;
        end else if (req_valid[i] && req_ready[i] && (grant_cnt[i*8 +: 8] != 8'hFF)) begin
          grant_cnt[i*8 +: 8] <= grant_cnt[i*8 +: 8] + 8'd1;
        end
      end
    end
  end
`endif

endmodule
